// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice with a registered carry,
// processing operands LSB first over WIDTH clocks, then a one-cycle DONE.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int IDXW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sum;
    logic [IDXW-1:0]   r_idx;
    logic              r_carry;
    logic              r_cout;
    logic              r_ovf;
    logic              r_busy;
    logic              r_done;
    logic              w_accept;
    logic              w_last;
    logic              w_sbit;
    logic              w_cnext;

    // Returns {carry_out, sum_bit} of a single full-adder slice.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
    endfunction

    // Acceptance, last-bit detection and the active bit slice.
    always_comb begin
        w_accept          = (r_state != RUN) && start;
        w_last            = (r_idx == IDXW'(WIDTH - 1));
        {w_cnext, w_sbit} = full_add(r_a[0], r_b[0], r_carry);
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = RUN;
                else       w_state_nxt = IDLE;
            end
            RUN: begin
                if (w_last) w_state_nxt = DONE;
                else        w_state_nxt = RUN;
            end
            DONE: begin
                if (start) w_state_nxt = RUN;
                else       w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == RUN);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    // Operand capture and serial datapath; operands shift right so bit 0 is always current.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sum   <= (r_sum >> 1) | (WIDTH'(w_sbit) << (WIDTH - 1));
            r_carry <= w_cnext;
            r_idx   <= r_idx + IDXW'(1);
            if (w_last) begin
                r_cout <= w_cnext;
                r_ovf  <= r_carry ^ w_cnext;
            end else begin
                r_cout <= r_cout;
                r_ovf  <= r_ovf;
            end
        end else begin
            r_a     <= r_a;
            r_b     <= r_b;
            r_sum   <= r_sum;
            r_carry <= r_carry;
            r_idx   <= r_idx;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an arithmetic reference model checked
// every cycle on a WIDTH=8 instance, plus directed cases on WIDTH=8 and WIDTH=1.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start, cin, sub;
    logic [7:0] a, b;
    logic       busy, done, cout, ovf;
    logic [7:0] sum;

    logic       s1_start, s1_a, s1_b, s1_cin, s1_sub;
    logic       s1_busy, s1_done, s1_sum, s1_cout, s1_ovf;

    int n_checks = 0;
    int n_err    = 0;

    serial_adder #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(ovf)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .a(s1_a), .b(s1_b), .cin(s1_cin),
        .sub(s1_sub), .busy(s1_busy), .done(s1_done), .sum(s1_sum), .cout(s1_cout),
        .overflow(s1_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result {overflow, cout, sum} from plain integer arithmetic.
    function automatic logic [9:0] ref_op(input logic [7:0] x, input logic [7:0] y,
                                          input logic c, input logic s);
        int ux, uy, sx, sy, full, sres;
        logic o, co;
        logic [7:0] r;
        ux = x;
        uy = y;
        sx = (ux > 127) ? ux - 256 : ux;
        sy = (uy > 127) ? uy - 256 : uy;
        if (s) begin
            full = ux + 256 - uy;
            sres = sx - sy;
        end else begin
            full = ux + uy + int'(c);
            sres = sx + sy + int'(c);
        end
        co = (full >= 256);
        o  = (sres > 127) || (sres < -128);
        r  = 8'(full % 256);
        return {o, co, r};
    endfunction

    // Behavioural model: remaining RUN cycles, done pulse and held results.
    int         m_left;
    logic       m_done;
    logic [7:0] m_sum;
    logic       m_cout, m_ovf;
    logic [9:0] m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_sum  <= 8'h00;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
            m_pend <= 10'h000;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                m_sum  <= m_pend[7:0];
                m_cout <= m_pend[8];
                m_ovf  <= m_pend[9];
            end
        end else if (start) begin
            m_left <= 8;
            m_done <= 1'b0;
            m_pend <= ref_op(a, b, cin, sub);
        end else begin
            m_done <= 1'b0;
        end
    end

    // Compare process on the falling edge.
    always @(negedge clk) begin
        chk("busy", {63'd0, busy}, {63'd0, (m_left > 0)});
        chk("done", {63'd0, done}, {63'd0, m_done});
        if (m_left == 0) begin
            chk("sum", {56'd0, sum}, {56'd0, m_sum});
            chk("cout", {63'd0, cout}, {63'd0, m_cout});
            chk("overflow", {63'd0, ovf}, {63'd0, m_ovf});
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                          input logic xs, input logic [7:0] e_sum, input logic e_cout,
                          input logic e_ovf);
        int n, nb;
        @(posedge clk);
        #1;
        a = xa; b = xb; cin = xc; sub = xs; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_accept", {63'd0, busy}, 64'd1);
        n = 0;
        nb = 0;
        while (done !== 1'b1 && n < 30) begin
            if (busy) nb++;
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 64'(n), 64'd8);
        chk("busy_cycles", 64'(nb), 64'd8);
        chk("lit_sum", {56'd0, sum}, {56'd0, e_sum});
        chk("lit_cout", {63'd0, cout}, {63'd0, e_cout});
        chk("lit_ovf", {63'd0, ovf}, {63'd0, e_ovf});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, tot;
        rst_n = 1'b0;
        start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
        s1_start = 1'b0; s1_a = 1'b0; s1_b = 1'b0; s1_cin = 1'b0; s1_sub = 1'b0;
        #3;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_sum", {56'd0, sum}, 64'd0);
        chk("rst_flags", {62'd0, cout, ovf}, 64'd0);
        #9;
        rst_n = 1'b1;

        // WIDTH=1 full-adder truth table
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            {s1_a, s1_b, s1_cin} = 3'(i);
            s1_start = 1'b1;
            @(posedge clk);
            #1;
            s1_start = 1'b0;
            chk("w1_busy", {63'd0, s1_busy}, 64'd1);
            chk("w1_done_early", {63'd0, s1_done}, 64'd0);
            @(posedge clk);
            #1;
            tot = int'(s1_a) + int'(s1_b) + int'(s1_cin);
            chk("w1_done", {63'd0, s1_done}, 64'd1);
            chk("w1_sum", {63'd0, s1_sum}, 64'(tot % 2));
            chk("w1_cout", {63'd0, s1_cout}, 64'(tot / 2));
        end

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);

        // start during RUN ignored, then back-to-back from DONE
        @(posedge clk);
        #1;
        a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        chk("ignored_start_sum", {56'd0, sum}, 64'h02);
        a = 8'h03; b = 8'h04; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        wait_done(n);
        chk("b2b_sum", {56'd0, sum}, 64'h07);

        // asynchronous reset mid-RUN
        @(posedge clk);
        #1;
        a = 8'hF2; b = 8'h34; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        chk("arst_sum", {56'd0, sum}, 64'd0);
        chk("arst_flags", {62'd0, cout, ovf}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk("no_done_after_reset", {63'd0, done}, 64'd0);
        end
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

        // randomized traffic checked by the model
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            start = ($urandom_range(0, 3) == 0);
            a     = 8'($urandom);
            b     = 8'($urandom);
            cin   = 1'($urandom);
            sub   = 1'($urandom);
        end
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
